// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Input conditioning in front of the ALU processing block.
//            - Two-flop synchroniser on the raw pushbuttons and switches.
//            - Independent debounce FSM per button channel.
//            - Clean debounced level plus one-cycle press/release pulses, so
//              the ALU sees exactly one event per physical press.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1      system clock
//   rst_ni         in   1      synchronous reset, active low
//   ena_i          in   1      block enable; low freezes debounce state
//   btn_raw_i      in   N_BTN  asynchronous buttons, bit0=btnL .. bit4=btnR
//   sw_raw_i       in   SW_W   asynchronous operand switches
//   sw_sync_o      out  SW_W   switches after the two-flop synchroniser
//   btn_level_o    out  N_BTN  debounced button level
//   btn_press_o    out  N_BTN  one-cycle pulse on debounced 0->1
//   btn_release_o  out  N_BTN  one-cycle pulse on debounced 1->0
// ----------------------------------------------------------------------------
// Parameters
//   N_BTN            number of independent button channels
//   SW_W             width of the switch bus
//   CNT_W            debounce counter width; 2**CNT_W must exceed
//                    DEBOUNCE_CYCLES so the limit is representable
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles needed before a
//                    new level is accepted (>= 1)
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int SW_W            = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic [SW_W-1:0]  sw_raw_i,
    output logic [SW_W-1:0]  sw_sync_o,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_deb_limit = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;

    // ------------------------------------------------------------------------
    // Debounce state encoding
    //   LOW  : accepted level 0, waiting for the input to go high
    //   RISE : input high, counting stable cycles before accepting 1
    //   HIGH : accepted level 1, waiting for the input to go low
    //   FALL : input low, counting stable cycles before accepting 0
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers. These keep running while ena_i is low so that
    // the debounce FSMs see current input values the moment they resume.
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] btn_meta_q;
    logic [N_BTN-1:0] btn_sync_q;
    logic [SW_W-1:0]  sw_meta_q;
    logic [SW_W-1:0]  sw_sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw_i;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_raw_i;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Switches are static operands: synchronised only, never debounced.
    assign sw_sync_o = sw_sync_q;

    // ------------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             sync_w;

        assign sync_w = btn_sync_q[gi];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q   <= ST_LOW;
                cnt_q     <= c_cnt_zero;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            // Hold by default; pulses default low so they last one cycle
            // and drop on the next edge even while frozen.
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;

            if (ena_i) begin
                case (state_q)
                    ST_LOW: begin
                        if (sync_w) begin
                            state_d = ST_RISE;
                            cnt_d   = c_cnt_one;
                        end
                    end

                    ST_RISE: begin
                        // A drop back to 0 aborts the count before the
                        // limit is even considered, so a glitch never
                        // produces a press.
                        if (!sync_w) begin
                            state_d = ST_LOW;
                            cnt_d   = c_cnt_zero;
                        end else if (cnt_q == c_deb_limit) begin
                            state_d = ST_HIGH;
                            cnt_d   = c_cnt_zero;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end

                    ST_HIGH: begin
                        if (!sync_w) begin
                            state_d = ST_FALL;
                            cnt_d   = c_cnt_one;
                        end
                    end

                    ST_FALL: begin
                        if (sync_w) begin
                            state_d = ST_HIGH;
                            cnt_d   = c_cnt_zero;
                        end else if (cnt_q == c_deb_limit) begin
                            state_d   = ST_LOW;
                            cnt_d     = c_cnt_zero;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end

                    default: begin
                        state_d = ST_LOW;
                        cnt_d   = c_cnt_zero;
                        level_d = 1'b0;
                    end
                endcase
            end
        end

        assign btn_level_o[gi]   = level_q;
        assign btn_press_o[gi]   = press_q;
        assign btn_release_o[gi] = release_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner with
//            DEBOUNCE_CYCLES=4, CNT_W=4. Expected pulse events are queued
//            when stimulus is applied and compared against the events seen
//            on the DUT outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

    localparam int D   = 4;
    localparam int LAT = D + 2;   // raw edge sampled at k -> outputs at k+LAT

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [4:0] btn_raw;
    logic [7:0] sw_raw;
    logic [7:0] sw_sync;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // number of rising edges so far

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (5),
        .SW_W           (8),
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ena_i         (ena),
        .btn_raw_i     (btn_raw),
        .sw_raw_i      (sw_raw),
        .sw_sync_o     (sw_sync),
        .btn_level_o   (btn_level),
        .btn_press_o   (btn_press),
        .btn_release_o (btn_release)
    );

    // Event recorder: logs every cycle with any pulse active.
    always @(posedge clk) begin
        ev_t ev;
        cyc++;
        #1;
        if ((btn_press | btn_release) != 5'd0) begin
            ev.cyc   = cyc;
            ev.press = btn_press;
            ev.rel   = btn_release;
            obs_q.push_back(ev);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic [4:0] p, input logic [4:0] r);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int k;
        ev_t e, o;
        rst_n   = 1'b0;
        ena     = 1'b1;
        btn_raw = 5'h1F;
        sw_raw  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({sw_sync, btn_level, btn_press, btn_release} !== 23'd0) begin
                bad++;
                $display("FAIL reset_outputs: got %h, want 0",
                         {sw_sync, btn_level, btn_press, btn_release});
            end
        end
        rst_n = 1'b1;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h1F, 5'h00);
        wait_until(k);
        total++;
        if (sw_sync !== 8'h00) begin
            bad++; $display("FAIL reset_sw_one_edge: got %h, want 00", sw_sync);
        end
        wait_until(k + 1);
        total++;
        if (sw_sync !== 8'hA5) begin
            bad++; $display("FAIL reset_sw_two_edges: got %h, want a5", sw_sync);
        end
        wait_until(k + LAT - 1);
        total++;
        if (btn_level !== 5'h00) begin
            bad++; $display("FAIL reset_level_early: got %h, want 00", btn_level);
        end
        wait_until(k + LAT);
        total++;
        if (btn_level !== 5'h1F) begin
            bad++; $display("FAIL reset_level_set: got %h, want 1f", btn_level);
        end
        btn_raw = 5'h00;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h1F);
        wait_until(k + LAT + 3);
        total++;
        if (btn_level !== 5'h00) begin
            bad++; $display("FAIL reset_level_clear: got %h, want 00", btn_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL reset_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL reset_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL reset_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clean_press();
        int k;
        ev_t e, o;
        @(negedge clk);
        btn_raw[1] = 1'b1;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h02, 5'h00);
        wait_until(k + LAT - 1);
        total++;
        if (btn_level[1] !== 1'b0) begin
            bad++; $display("FAIL press_level_early: got %b, want 0", btn_level[1]);
        end
        wait_until(k + LAT);
        total++;
        if (btn_level[1] !== 1'b1 || btn_press[1] !== 1'b1) begin
            bad++; $display("FAIL press_edge: got level=%b press=%b, want 1 1", btn_level[1], btn_press[1]);
        end
        wait_until(k + LAT + 12);
        total++;
        if (btn_level !== 5'h02) begin
            bad++; $display("FAIL press_held_level: got %h, want 02", btn_level);
        end
        btn_raw[1] = 1'b0;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h02);
        wait_until(k + LAT + 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL press_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL press_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL press_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_glitch();
        int k;
        ev_t e, o;
        // Three sampled-high cycles: must be rejected.
        @(negedge clk);
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        wait_until(k + 2);
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0) begin
                bad++; $display("FAIL glitch_reject: got level=%b press=%b, want 0 0", btn_level[0], btn_press[0]);
            end
        end
        // D+1 sampled-high cycles: just long enough to be accepted.
        @(negedge clk);
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h01, 5'h00);
        wait_until(k + D);
        btn_raw[0] = 1'b0;
        expect_ev(k + D + 1 + LAT, 5'h00, 5'h01);
        wait_until(k + D + 1 + LAT + 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL glitch_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL glitch_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL glitch_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bounce();
        logic [7:0] pat;
        logic       prev;
        int         last_rise;
        int         k;
        ev_t        e, o;
        pat = 8'b1110_1101;   // applied LSB first: 1,0,1,1,0,1,1,1
        last_rise = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            prev = btn_raw[2];
            btn_raw[2] = pat[i];
            if (pat[i] && !prev) last_rise = cyc + 1;
        end
        expect_ev(last_rise + LAT, 5'h04, 5'h00);
        wait_until(last_rise + LAT - 1);
        total++;
        if (btn_level[2] !== 1'b0) begin
            bad++; $display("FAIL bounce_level_early: got %b, want 0", btn_level[2]);
        end
        wait_until(last_rise + LAT + 5);
        total++;
        if (btn_level[2] !== 1'b1) begin
            bad++; $display("FAIL bounce_level: got %b, want 1", btn_level[2]);
        end
        btn_raw[2] = 1'b0;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h04);
        wait_until(k + LAT + 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL bounce_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL bounce_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL bounce_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_simultaneous();
        int k;
        ev_t e, o;
        @(negedge clk);
        btn_raw = 5'h11;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h11, 5'h00);
        wait_until(k + LAT + 4);
        total++;
        if (btn_level !== 5'h11) begin
            bad++; $display("FAIL simul_level: got %h, want 11", btn_level);
        end
        btn_raw = 5'h00;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h11);
        wait_until(k + LAT + 3);
        total++;
        if (btn_level !== 5'h00) begin
            bad++; $display("FAIL simul_level_clear: got %h, want 00", btn_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL simul_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL simul_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL simul_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_freeze();
        int k;
        int f;
        ev_t e, o;
        @(negedge clk);
        btn_raw[3] = 1'b1;
        k = cyc + 1;
        // Counter reaches 2 after edge k+3; ena low for the next 10 edges.
        expect_ev(k + LAT + 10, 5'h08, 5'h00);
        wait_until(k + 3);
        ena    = 1'b0;
        sw_raw = 8'h3C;
        f = cyc + 1;
        wait_until(f + 1);
        total++;
        if (sw_sync !== 8'h3C) begin
            bad++; $display("FAIL freeze_sw_runs: got %h, want 3c", sw_sync);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (btn_level[3] !== 1'b0 || btn_press[3] !== 1'b0) begin
                bad++; $display("FAIL freeze_hold: got level=%b press=%b, want 0 0", btn_level[3], btn_press[3]);
            end
        end
        ena = 1'b1;
        wait_until(k + LAT + 9);
        total++;
        if (btn_level[3] !== 1'b0) begin
            bad++; $display("FAIL freeze_level_early: got %b, want 0", btn_level[3]);
        end
        wait_until(k + LAT + 10);
        total++;
        if (btn_level[3] !== 1'b1) begin
            bad++; $display("FAIL freeze_resume_level: got %b, want 1", btn_level[3]);
        end
        btn_raw[3] = 1'b0;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h08);
        wait_until(k + LAT + 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL freeze_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL freeze_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL freeze_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_midcount();
        int k;
        int r;
        ev_t e, o;
        @(negedge clk);
        btn_raw[3] = 1'b1;
        k = cyc + 1;
        // Counter holds 3 after edge k+4; reset lands on edges k+5, k+6.
        wait_until(k + 4);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({sw_sync, btn_level, btn_press, btn_release} !== 23'd0) begin
                bad++;
                $display("FAIL midreset_outputs: got %h, want 0",
                         {sw_sync, btn_level, btn_press, btn_release});
            end
        end
        rst_n = 1'b1;
        r = cyc + 1;
        expect_ev(r + LAT, 5'h08, 5'h00);
        wait_until(r + 1);
        total++;
        if (sw_sync !== 8'h3C) begin
            bad++; $display("FAIL midreset_sw: got %h, want 3c", sw_sync);
        end
        wait_until(r + LAT - 1);
        total++;
        if (btn_level[3] !== 1'b0) begin
            bad++; $display("FAIL midreset_level_early: got %b, want 0", btn_level[3]);
        end
        wait_until(r + LAT);
        total++;
        if (btn_level[3] !== 1'b1) begin
            bad++; $display("FAIL midreset_level: got %b, want 1", btn_level[3]);
        end
        btn_raw[3] = 1'b0;
        k = cyc + 1;
        expect_ev(k + LAT, 5'h00, 5'h08);
        wait_until(k + LAT + 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL midreset_event: got none, want cyc=%0d press=%h rel=%h", e.cyc, e.press, e.rel);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.press !== e.press || o.rel !== e.rel) begin
                    bad++;
                    $display("FAIL midreset_event: got cyc=%0d press=%h rel=%h, want cyc=%0d press=%h rel=%h",
                             o.cyc, o.press, o.rel, e.cyc, e.press, e.rel);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL midreset_extra_events: got %0d, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_freeze();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
